// File: rtl/button_event_decoder_if.sv
// Strobe/pulse bundle between the debouncer side and the button event decoder.
interface button_event_decoder_if;
   logic btn_down;
   logic btn_up;
   logic short_press;
   logic long_press;
   logic repeat_pulse;
   logic double_press;
   logic held;

   modport master (
      output btn_down, btn_up,
      input  short_press, long_press, repeat_pulse, double_press, held
   );

   modport slave (
      input  btn_down, btn_up,
      output short_press, long_press, repeat_pulse, double_press, held
   );
endinterface

// File: rtl/button_event_decoder.sv
// Classifies debounced press/release strobes into short, long (+auto-repeat) and double presses.
// Optional double-press detection is built only when DOUBLE_PRESS_EN is defined.
module button_event_decoder #(
   parameter int CNT_W         = 24,
   parameter int LONG_CYCLES   = 12_500_000,
   parameter int REPEAT_CYCLES = 5_000_000,
   parameter int DOUBLE_CYCLES = 10_000_000
) (
   input  logic                        clk,
   input  logic                        rst_n,
   button_event_decoder_if.slave       bus
);

   if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2 || DOUBLE_CYCLES < 2) begin : g_bad_cycles
      $error("button_event_decoder: cycle parameters must be >= 2");
   end
   if (LONG_CYCLES - 1 >= (1 << CNT_W) || REPEAT_CYCLES - 1 >= (1 << CNT_W) ||
       DOUBLE_CYCLES - 1 >= (1 << CNT_W)) begin : g_bad_width
      $error("button_event_decoder: CNT_W too narrow for the cycle parameters");
   end

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PRESS = 3'd1,
      HOLD  = 3'd2
`ifdef DOUBLE_PRESS_EN
      ,
      WAIT2 = 3'd3,
      LOCK  = 3'd4
`endif
   } state_t;

   localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CYCLES - 1);
`ifdef DOUBLE_PRESS_EN
   localparam logic [CNT_W-1:0] DOUBLE_TERM = CNT_W'(DOUBLE_CYCLES - 1);
`endif

   state_t           state_r;
   state_t           state_next_s;
   logic [CNT_W-1:0] cnt_r;
   logic             cnt_clear_s;
   logic             counting_s;
   logic             down_s;
   logic             up_s;

   logic             short_next_s;
   logic             long_next_s;
   logic             repeat_next_s;
   logic             short_press_r;
   logic             long_press_r;
   logic             repeat_pulse_r;
   logic             held_r;
`ifdef DOUBLE_PRESS_EN
   logic             double_next_s;
   logic             double_press_r;
`endif

   // Coincident press and release cancel each other out.
   assign down_s = bus.btn_down & ~bus.btn_up;
   assign up_s   = bus.btn_up   & ~bus.btn_down;

   // Next-state, counter control and pulse decode.
   always_comb begin
      state_next_s  = state_r;
      cnt_clear_s   = 1'b0;
      counting_s    = 1'b0;
      short_next_s  = 1'b0;
      long_next_s   = 1'b0;
      repeat_next_s = 1'b0;
`ifdef DOUBLE_PRESS_EN
      double_next_s = 1'b0;
`endif
      case (state_r)
         IDLE: begin
            if (down_s) begin
               state_next_s = PRESS;
            end else begin
               state_next_s = IDLE;
            end
         end
         PRESS: begin
            counting_s = 1'b1;
            if (up_s) begin
`ifdef DOUBLE_PRESS_EN
               state_next_s = WAIT2;
`else
               short_next_s = 1'b1;
               state_next_s = IDLE;
`endif
            end else if (cnt_r == LONG_TERM) begin
               long_next_s  = 1'b1;
               state_next_s = HOLD;
            end else begin
               state_next_s = PRESS;
            end
         end
         HOLD: begin
            counting_s = 1'b1;
            if (up_s) begin
               state_next_s = IDLE;
            end else if (cnt_r == REPEAT_TERM) begin
               repeat_next_s = 1'b1;
               cnt_clear_s   = 1'b1;
               state_next_s  = HOLD;
            end else begin
               state_next_s = HOLD;
            end
         end
`ifdef DOUBLE_PRESS_EN
         WAIT2: begin
            counting_s = 1'b1;
            if (down_s) begin
               double_next_s = 1'b1;
               state_next_s  = LOCK;
            end else if (cnt_r == DOUBLE_TERM) begin
               short_next_s = 1'b1;
               state_next_s = IDLE;
            end else begin
               state_next_s = WAIT2;
            end
         end
         LOCK: begin
            if (up_s) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = LOCK;
            end
         end
`endif
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Counter clears on state entry and repeat; idles at zero in non-timing states.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_clear_s || (state_next_s != state_r) || !counting_s) begin
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

   // Registered event pulses and hold level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         short_press_r  <= 1'b0;
         long_press_r   <= 1'b0;
         repeat_pulse_r <= 1'b0;
         held_r         <= 1'b0;
      end else begin
         short_press_r  <= short_next_s;
         long_press_r   <= long_next_s;
         repeat_pulse_r <= repeat_next_s;
         held_r         <= (state_next_s == HOLD);
      end
   end

`ifdef DOUBLE_PRESS_EN
   // Registered double-press pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         double_press_r <= 1'b0;
      end else begin
         double_press_r <= double_next_s;
      end
   end

   assign bus.double_press = double_press_r;
`else
   assign bus.double_press = 1'b0;
`endif

   assign bus.short_press  = short_press_r;
   assign bus.long_press   = long_press_r;
   assign bus.repeat_pulse = repeat_pulse_r;
   assign bus.held         = held_r;

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder: expected events queued by stimulus, matched by a monitor.
module tb_button_event_decoder;

   localparam int K_SHORT = 0;
   localparam int K_LONG  = 1;
   localparam int K_REP   = 2;
   localparam int K_DBL   = 3;
   localparam int K_HRISE = 4;
   localparam int K_HFALL = 5;

   typedef struct {
      int kind;
      int edge_n;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   edge_cnt = 0;
   int   checks = 0;
   int   errors = 0;
   logic prev_held = 1'b0;
   exp_t exp_q[$];

   button_event_decoder_if bus();

   button_event_decoder #(
      .CNT_W(4), .LONG_CYCLES(8), .REPEAT_CYCLES(4), .DOUBLE_CYCLES(6)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   function automatic string kname(input int k);
      case (k)
         K_SHORT: return "short_press";
         K_LONG:  return "long_press";
         K_REP:   return "repeat_pulse";
         K_DBL:   return "double_press";
         K_HRISE: return "held_rise";
         K_HFALL: return "held_fall";
         default: return "unknown";
      endcase
   endfunction

   task automatic expect_ev(input int k, input int e);
      exp_t x;
      x.kind   = k;
      x.edge_n = e;
      exp_q.push_back(x);
   endtask

   task automatic match(input int k);
      int idx;
      idx = -1;
      foreach (exp_q[i]) begin
         if (idx < 0 && exp_q[i].kind == k && exp_q[i].edge_n == edge_cnt) idx = i;
      end
      checks++;
      if (idx < 0) begin
         errors++;
         $display("FAIL %s: seen after edge %0d, no such event expected", kname(k), edge_cnt);
      end else begin
         exp_q.delete(idx);
      end
   endtask

   // Monitor: every output event is matched against the scoreboard queue.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_held = 1'b0;
      end else begin
         if (bus.short_press)  match(K_SHORT);
         if (bus.long_press)   match(K_LONG);
         if (bus.repeat_pulse) match(K_REP);
         if (bus.double_press) match(K_DBL);
         if (bus.held && !prev_held) match(K_HRISE);
         if (!bus.held && prev_held) match(K_HFALL);
         prev_held = bus.held;
      end
   end

   task automatic chk(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %b want %b", name, act, req);
      end
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_short"},  bus.short_press,  1'b0);
      chk({tag, "_long"},   bus.long_press,   1'b0);
      chk({tag, "_repeat"}, bus.repeat_pulse, 1'b0);
      chk({tag, "_double"}, bus.double_press, 1'b0);
      chk({tag, "_held"},   bus.held,         1'b0);
   endtask

   // Present a strobe so that it is sampled by edge number e (called on a negedge).
   task automatic strobe(input int e, input logic d, input logic u);
      while (edge_cnt < e - 1) @(negedge clk);
      bus.btn_down = d;
      bus.btn_up   = u;
      @(negedge clk);
      bus.btn_down = 1'b0;
      bus.btn_up   = 1'b0;
   endtask

   task automatic run_end(input string name, input int settle);
      repeat (settle) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         foreach (exp_q[i])
            $display("FAIL %s: %s expected after edge %0d, not seen", name, kname(exp_q[i].kind),
                     exp_q[i].edge_n);
         exp_q.delete();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int base;
      rst_n        = 1'b0;
      bus.btn_down = 1'b0;
      bus.btn_up   = 1'b0;
      repeat (3) @(negedge clk);
      chk_outputs_zero("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1: short press
      base = edge_cnt + 1;
`ifdef DOUBLE_PRESS_EN
      expect_ev(K_SHORT, base + 9);
`else
      expect_ev(K_SHORT, base + 3);
`endif
      strobe(base + 0, 1'b1, 1'b0);
      strobe(base + 3, 1'b0, 1'b1);
      run_end("short", 16);

      // 2: long press with repeats
      base = edge_cnt + 1;
      expect_ev(K_LONG,  base + 8);
      expect_ev(K_HRISE, base + 8);
      expect_ev(K_REP,   base + 12);
      expect_ev(K_REP,   base + 16);
      expect_ev(K_REP,   base + 20);
      expect_ev(K_HFALL, base + 21);
      strobe(base + 0,  1'b1, 1'b0);
      strobe(base + 21, 1'b0, 1'b1);
      run_end("long", 16);

      // 3: release coincides with the long threshold
      base = edge_cnt + 1;
`ifdef DOUBLE_PRESS_EN
      expect_ev(K_SHORT, base + 14);
`else
      expect_ev(K_SHORT, base + 8);
`endif
      strobe(base + 0, 1'b1, 1'b0);
      strobe(base + 8, 1'b0, 1'b1);
      run_end("boundary", 16);

`ifdef DOUBLE_PRESS_EN
      // 4: double press
      base = edge_cnt + 1;
      expect_ev(K_DBL, base + 5);
      strobe(base + 0,  1'b1, 1'b0);
      strobe(base + 2,  1'b0, 1'b1);
      strobe(base + 5,  1'b1, 1'b0);
      strobe(base + 30, 1'b0, 1'b1);
      run_end("double", 16);
`endif

      // 5: reset while in HOLD
      base = edge_cnt + 1;
      expect_ev(K_LONG,  base + 8);
      expect_ev(K_HRISE, base + 8);
      strobe(base + 0, 1'b1, 1'b0);
      while (edge_cnt < base + 10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_outputs_zero("midhold_reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      strobe(base + 13, 1'b0, 1'b1);
      run_end("reset_hold", 20);

      // 6: simultaneous strobes in IDLE and in PRESS
      base = edge_cnt + 1;
      strobe(base + 0, 1'b1, 1'b1);
      base = base + 2;
      expect_ev(K_LONG,  base + 8);
      expect_ev(K_HRISE, base + 8);
      expect_ev(K_HFALL, base + 10);
      strobe(base + 0,  1'b1, 1'b0);
      strobe(base + 3,  1'b1, 1'b1);
      strobe(base + 10, 1'b0, 1'b1);
      run_end("simultaneous", 16);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Consumes the clean, single-cycle press/release strobes produced by the team's button debouncer and classifies each press as short, long (with auto-repeat while held) or double. It sits between the debouncer and the counter/control logic, so an up/down counter can step once per tap and step continuously while a button is held.

## Interface

Parameters:
- CNT_W, 24, width of the internal cycle counter; must hold max(LONG_CYCLES, REPEAT_CYCLES, DOUBLE_CYCLES) − 1
- LONG_CYCLES, 12_500_000, cycles a press must last to become a long press (≥ 2)
- REPEAT_CYCLES, 5_000_000, auto-repeat period while held after a long press (≥ 2)
- DOUBLE_CYCLES, 10_000_000, window after a short release in which a second press makes a double press (≥ 2)

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- btn_down  in  1  one-cycle strobe: debounced press
- btn_up  in  1  one-cycle strobe: debounced release
- short_press  out  1  one-cycle pulse: short press classified
- long_press  out  1  one-cycle pulse: press reached LONG_CYCLES
- repeat_pulse  out  1  one-cycle pulse every REPEAT_CYCLES while held after long_press
- double_press  out  1  one-cycle pulse: second press inside the window
- held  out  1  level; high while in HOLD

## Operation

- Single state machine plus one CNT_W counter. The counter clears on every state entry and increments every cycle otherwise.
- Input qualification: btn_down and btn_up asserted in the same cycle are treated as no event. A strobe that has no transition in the current state is ignored.
- IDLE: btn_down → PRESS.
- PRESS:
  - btn_up → WAIT2, or with the feature compiled out, emit short_press → IDLE.
  - Else, when cnt == LONG_CYCLES−1 → emit long_press → HOLD.
  - btn_up wins if it coincides with cnt == LONG_CYCLES−1.
- HOLD:
  - When cnt == REPEAT_CYCLES−1, emit repeat_pulse and clear cnt.
  - btn_up → IDLE with no pulse. btn_up wins over a coincident repeat.
- WAIT2:
  - btn_down → emit double_press → LOCK.
  - Else, when cnt == DOUBLE_CYCLES−1 → emit short_press → IDLE.
  - btn_down wins if it coincides with the timeout.
- LOCK: btn_up → IDLE. The second press never produces long_press or repeat_pulse.
- The counter saturates nowhere; every state that counts exits or clears at its terminal value, so there is no wrap-around.

## Timing

- All outputs are registered.
- A pulse is high for exactly the one cycle following the clock edge at which its condition is sampled.
- Edge numbering for a press: E0 is the edge that samples btn_down in IDLE.
  - long_press is high in the cycle after edge E(LONG_CYCLES).
  - The first repeat_pulse follows REPEAT_CYCLES edges later, then one every REPEAT_CYCLES.
- Without DOUBLE_PRESS_EN: short_press is high the cycle after the edge sampling btn_up.
- With DOUBLE_PRESS_EN:
  - short_press comes DOUBLE_CYCLES edges after the btn_up sample edge.
  - double_press is high the cycle after the edge sampling the second btn_down.
- held rises with long_press and falls the cycle after the btn_up sample edge.
- Reset (asynchronous, any time): state IDLE, cnt 0, short_press, long_press, repeat_pulse, double_press and held all 0. A pending short press in WAIT2 is discarded. The first event after rst_n deasserts is the first edge with rst_n high.

## Configuration

- DOUBLE_PRESS_EN:
  - Defined: WAIT2 and LOCK exist, double_press is live, and short_press is delayed by the double window.
  - Undefined: WAIT2/LOCK logic and DOUBLE_CYCLES comparison are not built, double_press is tied 0, and short_press fires one cycle after release.

## Test plan

Bench parameters: LONG_CYCLES=8, REPEAT_CYCLES=4, DOUBLE_CYCLES=6, CNT_W=4.

1. Short press: btn_down at E0, btn_up at E3.
   - Macro on: single short_press after E9, no other outputs.
   - Macro off: short_press after E3.
2. Long press: btn_down at E0, btn_up at E21.
   - long_press after E8; repeat_pulse after E12, E16, E20; held high from E8 until the cycle after E21.
   - No short_press.
3. Long/short boundary: btn_down at E0, btn_up at E8 (cnt == 7).
   - short path taken, no long_press, held stays 0.
4. Double press (macro on): down E0, up E2, down E5, up E30.
   - double_press after E5 only; no short_press, no long_press, held 0 throughout.
5. Reset mid-HOLD: in HOLD at cnt=2, rst_n low for 2 cycles, then btn_up.
   - All outputs 0 immediately on rst_n fall; the btn_up is ignored; no pulses follow.
6. Simultaneous strobes: btn_down and btn_up together in IDLE, then again in PRESS.
   - No state change, no outputs; the PRESS timer continues to long_press on schedule.
